// File: rtl/addsub_seq_if.sv
// rtl/addsub_seq_if.sv - operation/result handshake bundle for addsub_seq
// Purpose: groups the operand input handshake and the result output handshake.
// Ports (signals):
//   in_valid/in_ready        - operation handshake
//   x, y                     - WIDTH-bit operands
//   cin, sub, sat            - carry/borrow-in, subtract select, saturate enable
//   out_valid/out_ready      - result handshake
//   sum, cout, overflow,zero - result and flags
// Modports: master drives operations and consumes results; slave is the adder.
interface addsub_seq_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             cin;
   logic             sub;
   logic             sat;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;
   logic             zero;

   modport master (
      output in_valid, x, y, cin, sub, sat, out_ready,
      input  in_ready, out_valid, sum, cout, overflow, zero
   );

   modport slave (
      input  in_valid, x, y, cin, sub, sat, out_ready,
      output in_ready, out_valid, sum, cout, overflow, zero
   );
endinterface

// File: rtl/addsub_seq.sv
// rtl/addsub_seq.sv - multi-cycle chunked two's-complement adder/subtractor
// Purpose: adds or subtracts two WIDTH-bit operands CHUNK bits per clock over a
//   registered carry chain; reports raw carry, raw signed overflow, zero, and an
//   optionally saturated sum.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   bus - addsub_seq_if.slave: operation input (in_valid/in_ready/x/y/cin/sub/sat)
//         and result output (out_valid/out_ready/sum/cout/overflow/zero)
module addsub_seq #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic        clk,
   input  logic        rst,
   addsub_seq_if.slave bus
);
   localparam int N  = WIDTH / CHUNK;
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sum_q;
   logic [IW-1:0]    idx_q;
   logic             carry_q;
   logic             sat_q;
   logic             xmsb_q;
   logic             cout_q;
   logic             ovf_q;
   logic             zero_q;

   logic             accept;
   logic             last;
   logic [CHUNK:0]   chunk_add;
   logic             cin_msb;
   logic             ovf_raw;
   logic [WIDTH-1:0] sum_raw;
   logic [WIDTH-1:0] sum_final;

   assign accept = bus.in_valid && (state == IDLE);
   assign last   = (idx_q == IW'(N - 1));

   // Operands shift right each RUN cycle, so the active chunk is always the
   // low CHUNK bits; no width-dependent mux sits in front of the adder.
   assign chunk_add = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, carry_q};

   // Carry into the MSB recovered from the MSB sum bit (s = a ^ b ^ c_in).
   assign cin_msb = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ chunk_add[CHUNK-1];
   assign ovf_raw = cin_msb ^ chunk_add[CHUNK];

   // Full result as it will look after the last chunk, then saturated.
   always_comb begin
      sum_raw = sum_q;
      sum_raw[WIDTH-1 -: CHUNK] = chunk_add[CHUNK-1:0];
      sum_final = sum_raw;
      if (sat_q && ovf_raw) begin
         sum_final = xmsb_q ? {1'b1, {(WIDTH-1){1'b0}}}
                            : {1'b0, {(WIDTH-1){1'b1}}};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.in_valid)  state_nxt = RUN;
         RUN:     if (last)          state_nxt = DONE;
         DONE:    if (bus.out_ready) state_nxt = IDLE;
         default:                    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         sat_q   <= 1'b0;
         xmsb_q  <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else if (accept) begin
         // Subtraction is x + ~y + ~borrow.
         a_q     <= bus.x;
         b_q     <= bus.y ^ {WIDTH{bus.sub}};
         carry_q <= bus.cin ^ bus.sub;
         sat_q   <= bus.sat;
         xmsb_q  <= bus.x[WIDTH-1];
         idx_q   <= '0;
      end else if (state == RUN) begin
         a_q     <= a_q >> CHUNK;
         b_q     <= b_q >> CHUNK;
         carry_q <= chunk_add[CHUNK];
         sum_q[idx_q*CHUNK +: CHUNK] <= chunk_add[CHUNK-1:0];
         if (last) begin
            sum_q  <= sum_final;
            cout_q <= chunk_add[CHUNK];
            ovf_q  <= ovf_raw;
            zero_q <= (sum_final == '0);
         end else begin
            idx_q <= idx_q + IW'(1);
         end
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.overflow  = ovf_q;
   assign bus.zero      = zero_q;
endmodule

// File: tb/tb_addsub_seq.sv
// tb/tb_addsub_seq.sv - self-checking bench for addsub_seq
module tb_addsub_seq;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   addsub_seq_if #(.WIDTH(16)) b0 ();
   addsub_seq_if #(.WIDTH(32)) b1 ();
   addsub_seq_if #(.WIDTH(32)) b2 ();

   addsub_seq #(.WIDTH(16), .CHUNK(4))  u0 (.clk(clk), .rst(rst), .bus(b0.slave));
   addsub_seq #(.WIDTH(32), .CHUNK(32)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
   addsub_seq #(.WIDTH(32), .CHUNK(8))  u2 (.clk(clk), .rst(rst), .bus(b2.slave));

   int wid [3] = '{16, 32, 32};
   int nch [3] = '{4, 1, 4};

   logic [31:0] o_sum [3];
   logic [2:0]  o_valid, o_inrdy, o_cout, o_ovf, o_zero;
   assign o_sum[0] = {16'h0, b0.sum};
   assign o_sum[1] = b1.sum;
   assign o_sum[2] = b2.sum;
   assign o_valid  = {b2.out_valid, b1.out_valid, b0.out_valid};
   assign o_inrdy  = {b2.in_ready,  b1.in_ready,  b0.in_ready};
   assign o_cout   = {b2.cout,      b1.cout,      b0.cout};
   assign o_ovf    = {b2.overflow,  b1.overflow,  b0.overflow};
   assign o_zero   = {b2.zero,      b1.zero,      b0.zero};

   typedef struct packed {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
      logic        zero;
   } res_t;

   typedef struct packed {
      logic [31:0] x;
      logic [31:0] y;
      logic        c;
      logic        s;
      logic        st;
      res_t        e;
   } vec_t;

   function automatic vec_t mk(input logic [31:0] x, y, input bit c, s, st, input res_t e);
      vec_t v;
      v.x = x; v.y = y; v.c = c; v.s = s; v.st = st; v.e = e;
      return v;
   endfunction

   // Reference: true integer arithmetic, then range checks for the flags.
   function automatic res_t model(input int w, input logic [31:0] xx, yy, input bit c, s, st);
      res_t   r;
      longint one  = 1;
      longint m    = (one << w) - 1;
      longint ux   = longint'(xx) & m;
      longint uy   = longint'(yy) & m;
      longint half = one << (w - 1);
      longint sx   = (ux >= half) ? ux - (one << w) : ux;
      longint sy   = (uy >= half) ? uy - (one << w) : uy;
      longint ci   = c ? 1 : 0;
      longint ures, sres;
      if (!s) begin
         ures   = ux + uy + ci;
         sres   = sx + sy + ci;
         r.cout = (ures > m);
      end else begin
         ures   = ux - uy - ci;
         sres   = sx - sy - ci;
         r.cout = (ux >= uy + ci);
      end
      r.ovf = (sres > half - 1) || (sres < -half);
      r.sum = 32'(ures & m);
      if (st && r.ovf) r.sum = (sx < 0) ? 32'(half) : 32'(half - 1);
      r.zero = (r.sum == 32'h0);
      return r;
   endfunction

   function automatic logic [31:0] pick(input int w);
      longint one = 1;
      longint m   = (one << w) - 1;
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'(m);
         2:       return 32'(one << (w - 1));
         3:       return 32'((one << (w - 1)) - 1);
         default: return 32'(longint'($urandom) & m);
      endcase
   endfunction

   task automatic drive(input int i, input bit v, input logic [31:0] xx, yy, input bit c, s, st);
      case (i)
         0: begin b0.in_valid = v; b0.x = xx[15:0]; b0.y = yy[15:0];
                  b0.cin = c; b0.sub = s; b0.sat = st; end
         1: begin b1.in_valid = v; b1.x = xx; b1.y = yy;
                  b1.cin = c; b1.sub = s; b1.sat = st; end
         default: begin b2.in_valid = v; b2.x = xx; b2.y = yy;
                  b2.cin = c; b2.sub = s; b2.sat = st; end
      endcase
   endtask

   task automatic set_oready(input int i, input bit r);
      case (i)
         0:       b0.out_ready = r;
         1:       b1.out_ready = r;
         default: b2.out_ready = r;
      endcase
   endtask

   // Issues one operation from IDLE, returns the result and the number of edges
   // from the input handshake to out_valid (50 means it never came).
   task automatic run_op(input int i, input logic [31:0] xx, yy, input bit c, s, st,
                         input bit release_out, output res_t got, output int lat);
      drive(i, 1'b1, xx, yy, c, s, st);
      @(posedge clk); #1;
      drive(i, 1'b0, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!o_valid[i] && lat < 50);
      got = {o_sum[i], o_cout[i], o_ovf[i], o_zero[i]};
      if (release_out) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({o_valid[i], o_sum[i], o_cout[i], o_ovf[i], o_zero[i], o_inrdy[i]} !== {1'b0, 32'h0, 4'b0001}) begin
            errors++;
            $display("FAIL reset[%0d] valid=%b sum=%h c=%b v=%b z=%b rdy=%b want 0/0/0/0/0/1",
                     i, o_valid[i], o_sum[i], o_cout[i], o_ovf[i], o_zero[i], o_inrdy[i]);
         end
      end
   endtask

   task automatic test_add();
      vec_t v [2];
      res_t got;
      int   lat;
      v[0] = mk(32'h1234, 32'h0FFF, 0, 0, 0, {32'h2233, 3'b000});
      v[1] = mk(32'hFFFF, 32'h0000, 1, 0, 0, {32'h0000, 3'b101});
      for (int k = 0; k < 2; k++) begin
         run_op(0, v[k].x, v[k].y, v[k].c, v[k].s, v[k].st, 1'b1, got, lat);
         checks++;
         if (got !== v[k].e) begin
            errors++;
            $display("FAIL add[%0d] got=%h want=%h", k, got, v[k].e);
         end
         checks++;
         if (lat !== 4) begin
            errors++;
            $display("FAIL add_latency[%0d] got=%0d want=4", k, lat);
         end
      end
   endtask

   task automatic test_sub();
      vec_t v [3];
      res_t got;
      int   lat;
      v[0] = mk(32'h0005, 32'h0007, 0, 1, 0, {32'hFFFE, 3'b000});
      v[1] = mk(32'h1234, 32'h1234, 0, 1, 0, {32'h0000, 3'b101});
      v[2] = mk(32'h0005, 32'h0002, 1, 1, 0, {32'h0002, 3'b100});
      for (int k = 0; k < 3; k++) begin
         run_op(0, v[k].x, v[k].y, v[k].c, v[k].s, v[k].st, 1'b1, got, lat);
         checks++;
         if (got !== v[k].e || lat !== 4) begin
            errors++;
            $display("FAIL sub[%0d] got=%h lat=%0d want=%h lat=4", k, got, lat, v[k].e);
         end
      end
   endtask

   task automatic test_sat();
      vec_t v [3];
      res_t got;
      int   lat;
      v[0] = mk(32'h7FFF, 32'h0001, 0, 0, 0, {32'h8000, 3'b010});
      v[1] = mk(32'h7FFF, 32'h0001, 0, 0, 1, {32'h7FFF, 3'b010});
      v[2] = mk(32'h8000, 32'h0001, 0, 1, 1, {32'h8000, 3'b110});
      for (int k = 0; k < 3; k++) begin
         run_op(0, v[k].x, v[k].y, v[k].c, v[k].s, v[k].st, 1'b1, got, lat);
         checks++;
         if (got !== v[k].e || lat !== 4) begin
            errors++;
            $display("FAIL sat[%0d] got=%h lat=%0d want=%h lat=4", k, got, lat, v[k].e);
         end
      end
   endtask

   task automatic test_backpressure();
      res_t got, exp;
      int   lat;
      exp = {32'h7FFF, 3'b010};
      set_oready(0, 1'b0);
      run_op(0, 32'h7FFF, 32'h0001, 0, 0, 1, 1'b0, got, lat);
      checks++;
      if (got !== exp || lat !== 4) begin
         errors++;
         $display("FAIL bp_result got=%h lat=%0d want=%h lat=4", got, lat, exp);
      end
      for (int k = 0; k < 10; k++) begin
         drive(0, 1'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
         @(posedge clk); #1;
         checks++;
         if ({o_valid[0], o_inrdy[0], o_sum[0], o_cout[0], o_ovf[0], o_zero[0]} !== {2'b10, exp}) begin
            errors++;
            $display("FAIL bp_hold[%0d] valid=%b rdy=%b res=%h want 1/0/%h", k, o_valid[0], o_inrdy[0],
                     {o_sum[0], o_cout[0], o_ovf[0], o_zero[0]}, exp);
         end
      end
      drive(0, 1'b0, 32'h0, 32'h0, 0, 0, 0);
      set_oready(0, 1'b1);
      @(posedge clk); #1;
      checks++;
      if ({o_valid[0], o_inrdy[0]} !== 2'b01) begin
         errors++;
         $display("FAIL bp_release valid=%b rdy=%b want 0/1", o_valid[0], o_inrdy[0]);
      end
   endtask

   task automatic test_reset_mid();
      res_t got;
      int   lat;
      drive(0, 1'b1, 32'h1111, 32'h2222, 0, 0, 0);
      @(posedge clk); #1;
      drive(0, 1'b0, 32'h0, 32'h0, 0, 0, 0);
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
      #1;
      checks++;
      if ({o_valid[0], o_inrdy[0], o_sum[0]} !== {2'b01, 32'h0}) begin
         errors++;
         $display("FAIL rst_run valid=%b rdy=%b sum=%h want 0/1/0", o_valid[0], o_inrdy[0], o_sum[0]);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      run_op(0, 32'h0001, 32'h0001, 0, 0, 0, 1'b1, got, lat);
      checks++;
      if (got !== {32'h0002, 3'b000} || lat !== 4) begin
         errors++;
         $display("FAIL rst_after got=%h lat=%0d want=%h lat=4", got, lat, {32'h0002, 3'b000});
      end
      set_oready(0, 1'b0);
      run_op(0, 32'hFFFF, 32'h0001, 0, 0, 0, 1'b0, got, lat);
      rst = 1'b1;
      #1;
      checks++;
      if ({o_valid[0], o_inrdy[0], o_sum[0], o_cout[0], o_ovf[0], o_zero[0]} !== {2'b01, 35'h0}) begin
         errors++;
         $display("FAIL rst_done valid=%b rdy=%b res=%h want 0/1/0", o_valid[0], o_inrdy[0],
                  {o_sum[0], o_cout[0], o_ovf[0], o_zero[0]});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      set_oready(0, 1'b1);
   endtask

   task automatic test_wide_single();
      res_t got;
      int   lat;
      run_op(1, 32'hFFFF_FFFF, 32'h1, 0, 0, 0, 1'b1, got, lat);
      checks++;
      if (got !== {32'h0, 3'b101} || lat !== 1) begin
         errors++;
         $display("FAIL wide_single got=%h lat=%0d want=%h lat=1", got, lat, {32'h0, 3'b101});
      end
   endtask

   task automatic test_random();
      res_t        got, exp;
      int          lat;
      logic [31:0] xx, yy;
      bit          c, s, st;
      for (int i = 0; i < 3; i += 2) begin
         for (int k = 0; k < 40; k++) begin
            xx = pick(wid[i]);
            yy = pick(wid[i]);
            c  = 1'($urandom);
            s  = 1'($urandom);
            st = 1'($urandom);
            exp = model(wid[i], xx, yy, c, s, st);
            run_op(i, xx, yy, c, s, st, 1'b1, got, lat);
            checks++;
            if (got !== exp || lat !== nch[i]) begin
               errors++;
               $display("FAIL random[%0d.%0d] x=%h y=%h c=%b s=%b sat=%b got=%h lat=%0d want=%h lat=%0d",
                        i, k, xx, yy, c, s, st, got, lat, exp, nch[i]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int acc [$];
      int waited;
      set_oready(0, 1'b1);
      drive(0, 1'b1, 32'h0010, 32'h0020, 0, 0, 0);
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (o_inrdy[0]) acc.push_back(cyc);
         @(posedge clk); #1;
      end
      drive(0, 1'b0, 32'h0, 32'h0, 0, 0, 0);
      checks++;
      if (acc.size() < 3) begin
         errors++;
         $display("FAIL b2b_count got=%0d want>=3", acc.size());
      end else begin
         checks++;
         if (acc[1] - acc[0] !== 6 || acc[2] - acc[1] !== 6) begin
            errors++;
            $display("FAIL b2b_interval got=%0d,%0d want=6,6", acc[1] - acc[0], acc[2] - acc[1]);
         end
      end
      waited = 0;
      while (!(o_inrdy[0] && !o_valid[0]) && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      checks++;
      if (o_inrdy[0] !== 1'b1) begin
         errors++;
         $display("FAIL b2b_drain rdy=%b want 1", o_inrdy[0]);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(i, 1'b0, 32'h0, 32'h0, 0, 0, 0);
         set_oready(i, 1'b1);
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_add();
      test_sub();
      test_sat();
      test_backpressure();
      test_reset_mid();
      test_wide_single();
      test_random();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/addsub_seq.md
# addsub_seq

Parametrised multi-cycle two's-complement adder/subtractor. It processes a WIDTH-bit operation CHUNK bits per clock over a registered carry chain, and reports carry, signed overflow, zero and an optional saturated result. It replaces the fixed 16-bit combinational add/sub in datapaths where timing matters more than latency. It connects to the ALU control through a valid/ready handshake on both input and output.

## Interface
- WIDTH, 16: operand and result width; must be a multiple of CHUNK.
- CHUNK, 4: bits added per cycle. N = WIDTH/CHUNK is the number of compute cycles. CHUNK = WIDTH is legal (N = 1).
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and controls are valid.
- in_ready  out  1  block can accept an operation; high only in IDLE.
- x  in  WIDTH  first operand.
- y  in  WIDTH  second operand.
- cin  in  1  add: carry-in; sub: borrow-in.
- sub  in  1  0 = x+y+cin; 1 = x−y−cin.
- sat  in  1  1 = saturate sum on signed overflow.
- out_valid  out  1  result registers hold a completed result.
- out_ready  in  1  consumer takes the result.
- sum  out  WIDTH  result; saturated if sat && overflow.
- cout  out  1  raw carry out of the MSB. For sub, 1 means no borrow.
- overflow  out  1  raw signed overflow: carry into MSB XOR carry out of MSB.
- zero  out  1  final sum == 0.

## Operation
- States: IDLE, RUN, DONE. Reset leaves the block in IDLE.
- IDLE → RUN on an edge where in_valid && in_ready.
  - At that edge the block latches x, y ^ {WIDTH{sub}}, sat, and the initial carry c0.
  - c0 = cin when sub = 0; c0 = ~cin when sub = 1.
  - The chunk index is cleared to 0.
- In RUN, each edge adds chunk k (bits k·CHUNK+CHUNK−1 … k·CHUNK) of the latched operands with the registered carry.
  - The block writes the sum chunk and stores the chunk carry-out as the carry for the next chunk.
  - In the last chunk, the carry into the MSB is also captured, for the overflow computation.
- RUN → DONE on the edge that processes chunk N−1.
  - On that edge the block registers cout, overflow and zero, and applies saturation.
  - out_valid rises on that edge.
- Saturation: if sat && overflow, sum becomes {0,1…1} when x[MSB] = 0 and {1,0…0} when x[MSB] = 1.
  - cout and overflow always report the raw, unsaturated values.
  - zero reflects the final, post-saturation sum.
- DONE → IDLE on an edge where out_valid && out_ready. out_valid falls on that edge.
- There is no same-cycle turnaround: in_ready is low in DONE, so a new operation is accepted no earlier than the edge after the output handshake.
- Operand inputs are ignored outside the accepting edge. sum, cout, overflow and zero stay stable from the rise of out_valid until the output handshake completes.
- In DONE, out_valid is held indefinitely while out_ready = 0.

## Timing
- Reset values: out_valid = 0, sum = 0, cout = 0, overflow = 0, zero = 0, in_ready = 1, state IDLE.
- Assertion of rst, including mid-RUN or in DONE, immediately aborts the operation with no result.
- Latency: the input handshake at edge t gives out_valid = 1 after edge t+N.
- Maximum throughput: one operation per N+2 cycles, with out_ready held high.
- Critical path: one CHUNK-bit adder plus the carry register. It is independent of WIDTH.
- Width rules:
  - Internal chunk adds are CHUNK+1 bits wide.
  - The carry register is 1 bit.
  - The chunk index is ceil(log2(N)) bits, minimum 1, and counts 0 … N−1 without wrap in normal operation.

## Test plan
Default parameters WIDTH = 16, CHUNK = 4 unless stated.

1. Add: x = 0x1234, y = 0x0FFF, cin = 0, sub = 0 → sum = 0x2233, cout = 0, overflow = 0, zero = 0. out_valid must rise exactly 4 cycles after the input handshake.
2. Subtract with borrow:
   - x = 0x0005, y = 0x0007, sub = 1, cin = 0 → sum = 0xFFFE, cout = 0.
   - x = 0x1234, y = 0x1234, sub = 1, cin = 0 → sum = 0x0000, zero = 1, cout = 1.
   - x = 0x0005, y = 0x0002, sub = 1, cin = 1 → sum = 0x0002.
3. Overflow and saturation:
   - 0x7FFF + 0x0001 with sat = 0 → sum = 0x8000, overflow = 1.
   - Same with sat = 1 → sum = 0x7FFF, overflow = 1, cout = 0.
   - 0x8000 − 0x0001 with sat = 1 → sum = 0x8000, overflow = 1, cout = 1.
4. Backpressure: hold out_ready = 0 for 10 cycles after completion.
   - out_valid, sum and flags stay constant throughout.
   - in_ready stays 0 while x/y/in_valid toggle.
   - Releasing out_ready completes the handshake, and in_ready = 1 on the next cycle.
5. Reset mid-operation: assert rst after 2 RUN cycles → out_valid = 0, sum = 0, in_ready = 1 immediately. A following 0x0001 + 0x0001 returns 0x0002.
6. Parameter sweep:
   - WIDTH = 32, CHUNK = 32: 0xFFFFFFFF + 1 → sum = 0, cout = 1, zero = 1, latency 1 cycle.
   - WIDTH = 32, CHUNK = 8: random add/sub/sat checked against a reference model, latency 4 cycles.
